// File: rtl/bf16_sub_pipe_if.sv
// Handshake and operand/result bus for the BF16 subtract pipeline.
// slave  : pipeline side (takes operands, returns ready_o and the result)
// master : producer/consumer side (drives operands and ready_i)
interface bf16_sub_pipe_if;
  logic       valid_i;
  logic       ready_o;
  logic       sa_i;
  logic [7:0] ea_i;
  logic [6:0] ma_i;
  logic       sb_i;
  logic [7:0] eb_i;
  logic [6:0] mb_i;
  logic       valid_o;
  logic       ready_i;
  logic       s_o;
  logic [7:0] e_o;
  logic [6:0] m_o;

  modport slave (
    input  valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i, ready_i,
    output ready_o, valid_o, s_o, e_o, m_o
  );

  modport master (
    output valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i, ready_i,
    input  ready_o, valid_o, s_o, e_o, m_o
  );
endinterface

// File: rtl/bf16_sub_pipe.sv
// Three-stage BF16 subtractor, result = a - b, round-to-nearest-even,
// flush-to-zero on inputs with exponent 0 and on results below exponent 1.
// Ports:
//   clk    - rising-edge clock
//   nreset - asynchronous active-low reset
//   bus    - operand pair in (valid_i/ready_o), result out (valid_o/ready_i)
// Stages: S1 unpack/specials/align, S2 add-sub/normalize, S3 round/pack.
// ready_o is the single enable for every stage, so a stalled output
// freezes the whole pipe.
module bf16_sub_pipe (
  input  logic                clk,
  input  logic                nreset,
  bf16_sub_pipe_if.slave      bus
);

  logic w_en;
  assign w_en       = !(bus.valid_o && !bus.ready_i);
  assign bus.ready_o = w_en;

  // ---------------- S1: unpack, specials, alignment ----------------
  logic       w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [7:0] w_sig_a, w_sig_b;
  logic       w_a_big;
  logic       w_big_s, w_sml_s;
  logic [7:0] w_big_e, w_sml_e, w_big_sig, w_sml_sig, w_shift;
  logic [10:0] w_sml_ext, w_sml_mask, w_sml_al;

  assign w_a_zero = (bus.ea_i == 8'h00);
  assign w_b_zero = (bus.eb_i == 8'h00);
  assign w_a_inf  = (bus.ea_i == 8'hFF) && (bus.ma_i == 7'h00);
  assign w_b_inf  = (bus.eb_i == 8'hFF) && (bus.mb_i == 7'h00);
  assign w_a_nan  = (bus.ea_i == 8'hFF) && (bus.ma_i != 7'h00);
  assign w_b_nan  = (bus.eb_i == 8'hFF) && (bus.mb_i != 7'h00);
  assign w_sig_a  = w_a_zero ? 8'h00 : {1'b1, bus.ma_i};
  assign w_sig_b  = w_b_zero ? 8'h00 : {1'b1, bus.mb_i};

  // Order by magnitude so S2 only ever subtracts the smaller from the larger.
  assign w_a_big   = {bus.ea_i, w_sig_a[6:0]} >= {bus.eb_i, w_sig_b[6:0]};
  assign w_big_s   = w_a_big ? bus.sa_i  : ~bus.sb_i;
  assign w_sml_s   = w_a_big ? ~bus.sb_i : bus.sa_i;
  assign w_big_e   = w_a_big ? bus.ea_i  : bus.eb_i;
  assign w_sml_e   = w_a_big ? bus.eb_i  : bus.ea_i;
  assign w_big_sig = w_a_big ? w_sig_a   : w_sig_b;
  assign w_sml_sig = w_a_big ? w_sig_b   : w_sig_a;
  assign w_shift   = w_big_e - w_sml_e;
  assign w_sml_ext = {w_sml_sig, 3'b000};

  // Guard/round bits plus a sticky bit jammed into the LSB.
  always_comb begin
    w_sml_mask = 11'd0;
    w_sml_al   = {10'd0, |w_sml_sig};
    if (w_shift < 8'd11) begin
      w_sml_mask = (11'd1 << w_shift[3:0]) - 11'd1;
      w_sml_al   = (w_sml_ext >> w_shift[3:0]) | {10'd0, |(w_sml_ext & w_sml_mask)};
    end
  end

  logic        r1_valid, r1_nan, r1_inf, r1_inf_s, r1_zero_s, r1_sign, r1_sub;
  logic [7:0]  r1_exp;
  logic [10:0] r1_big, r1_sml;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r1_valid  <= 1'b0;
      r1_nan    <= 1'b0;
      r1_inf    <= 1'b0;
      r1_inf_s  <= 1'b0;
      r1_zero_s <= 1'b0;
      r1_sign   <= 1'b0;
      r1_sub    <= 1'b0;
      r1_exp    <= 8'd0;
      r1_big    <= 11'd0;
      r1_sml    <= 11'd0;
    end else if (w_en) begin
      r1_valid  <= bus.valid_i;
      // inf - inf with equal signs is the only invalid combination of infinities.
      r1_nan    <= w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (bus.sa_i == bus.sb_i));
      r1_inf    <= w_a_inf || w_b_inf;
      r1_inf_s  <= w_a_inf ? bus.sa_i : ~bus.sb_i;
      // An exact zero sum is negative only when both addends are -0.
      r1_zero_s <= bus.sa_i & ~bus.sb_i;
      r1_sign   <= w_big_s;
      r1_sub    <= w_big_s ^ w_sml_s;
      r1_exp    <= w_big_e;
      r1_big    <= {w_big_sig, 3'b000};
      r1_sml    <= w_sml_al;
    end
  end

  // ---------------- S2: add/subtract, normalize ----------------
  logic [11:0] w_sum;
  logic [3:0]  w_lzc;
  logic [10:0] w_norm;
  logic [9:0]  w_exp;

  assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                        : ({1'b0, r1_big} + {1'b0, r1_sml});

  always_comb begin
    w_lzc = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (w_sum[i]) w_lzc = 4'(10 - i);
    end
  end

  // Exponent is kept 10 bits wide so a deep cancellation goes negative
  // instead of wrapping into a large value.
  always_comb begin
    if (w_sum[11]) begin
      w_norm = {w_sum[11:2], w_sum[1] | w_sum[0]};
      w_exp  = {2'b00, r1_exp} + 10'd1;
    end else begin
      w_norm = w_sum[10:0] << w_lzc;
      w_exp  = {2'b00, r1_exp} - {6'd0, w_lzc};
    end
  end

  logic        r2_valid, r2_nan, r2_inf, r2_inf_s, r2_zero_s, r2_sign, r2_zero;
  logic [9:0]  r2_exp;
  logic [10:0] r2_norm;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r2_valid  <= 1'b0;
      r2_nan    <= 1'b0;
      r2_inf    <= 1'b0;
      r2_inf_s  <= 1'b0;
      r2_zero_s <= 1'b0;
      r2_sign   <= 1'b0;
      r2_zero   <= 1'b0;
      r2_exp    <= 10'd0;
      r2_norm   <= 11'd0;
    end else if (w_en) begin
      r2_valid  <= r1_valid;
      r2_nan    <= r1_nan;
      r2_inf    <= r1_inf;
      r2_inf_s  <= r1_inf_s;
      r2_zero_s <= r1_zero_s;
      r2_sign   <= r1_sign;
      r2_zero   <= (w_sum == 12'd0);
      r2_exp    <= w_exp;
      r2_norm   <= w_norm;
    end
  end

  // ---------------- S3: round, pack ----------------
  logic       w_up;
  logic [8:0] w_rsig;
  logic [9:0] w_rexp;
  logic [6:0] w_rman;
  logic       w_res_s;
  logic [7:0] w_res_e;
  logic [6:0] w_res_m;

  assign w_up   = r2_norm[2] & (r2_norm[3] | r2_norm[1] | r2_norm[0]);
  assign w_rsig = {1'b0, r2_norm[10:3]} + {8'd0, w_up};
  assign w_rexp = r2_exp + {9'd0, w_rsig[8]};
  assign w_rman = w_rsig[8] ? w_rsig[7:1] : w_rsig[6:0];

  always_comb begin
    w_res_s = r2_sign;
    w_res_e = w_rexp[7:0];
    w_res_m = w_rman;
    if (r2_nan) begin
      w_res_s = 1'b0;
      w_res_e = 8'hFF;
      w_res_m = 7'h40;
    end else if (r2_inf) begin
      w_res_s = r2_inf_s;
      w_res_e = 8'hFF;
      w_res_m = 7'h00;
    end else if (r2_zero) begin
      w_res_s = r2_zero_s;
      w_res_e = 8'h00;
      w_res_m = 7'h00;
    end else if ($signed(r2_exp) < 10'sd1) begin
      w_res_e = 8'h00;
      w_res_m = 7'h00;
    end else if (w_rexp >= 10'd255) begin
      w_res_e = 8'hFF;
      w_res_m = 7'h00;
    end
  end

  logic       r3_valid, r3_s;
  logic [7:0] r3_e;
  logic [6:0] r3_m;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r3_valid <= 1'b0;
      r3_s     <= 1'b0;
      r3_e     <= 8'd0;
      r3_m     <= 7'd0;
    end else if (w_en) begin
      r3_valid <= r2_valid;
      r3_s     <= w_res_s;
      r3_e     <= w_res_e;
      r3_m     <= w_res_m;
    end
  end

  assign bus.valid_o = r3_valid;
  assign bus.s_o     = r3_s;
  assign bus.e_o     = r3_e;
  assign bus.m_o     = r3_m;

endmodule

// File: tb/tb_bf16_sub_pipe.sv
module tb_bf16_sub_pipe;
  logic clk = 1'b0;
  logic nreset;
  int   errors = 0;
  int   checks = 0;

  bf16_sub_pipe_if bus ();

  bf16_sub_pipe dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (real arithmetic) ----------------
  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  function automatic real to_real(input logic [15:0] x);
    logic [63:0] d;
    if (x[14:7] == 8'h00)      d = {x[15], 63'd0};
    else if (x[14:7] == 8'hFF) d = {x[15], 11'h7FF, 52'd0};
    else                       d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [63:0] d;
    logic [52:0] mant;
    logic [8:0]  q;
    logic [44:0] rem, half;
    int          ex;
    if (is_nan(a) || is_nan(b)) return 16'h7FC0;
    d = $realtobits(to_real(a) - to_real(b));
    if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? 16'h7FC0 : {d[63], 8'hFF, 7'h00};
    if (d[62:52] == 11'h000) return {d[63], 15'd0};
    mant = {1'b1, d[51:0]};
    q    = {1'b0, mant[52:45]};
    rem  = mant[44:0];
    half = 45'd1 << 44;
    if (rem > half || (rem == half && q[0])) q = q + 9'd1;
    ex = int'(d[62:52]) - 896;
    if (q[8]) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {d[63], 8'hFF, 7'h00};
    if (ex < 1)    return {d[63], 15'd0};
    return {d[63], ex[7:0], q[6:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    int k;
    k = $urandom_range(0, 99);
    if (k < 4)      return {1'($urandom), 8'h00, 7'($urandom)};
    else if (k < 7) return {1'($urandom), 8'hFF, 7'h00};
    else if (k < 9) return {1'($urandom), 8'hFF, 7'($urandom_range(1, 127))};
    return {1'($urandom), 8'($urandom_range(40, 215)), 7'($urandom)};
  endfunction

  task automatic drive_op(input logic v, input logic [15:0] a, input logic [15:0] b);
    bus.valid_i = v;
    bus.sa_i = a[15]; bus.ea_i = a[14:7]; bus.ma_i = a[6:0];
    bus.sb_i = b[15]; bus.eb_i = b[14:7]; bus.mb_i = b[6:0];
  endtask

  function automatic logic [15:0] out_word();
    return {bus.s_o, bus.e_o, bus.m_o};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    bus.ready_i = 1'b0;
    drive_op(1'b1, 16'h3F80, 16'h3F00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %b want 0", bus.valid_o); end
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o: got %b want 1", bus.ready_o); end
    checks++;
    if (out_word() !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", out_word()); end
    drive_op(1'b0, 16'h0, 16'h0);
    bus.ready_i = 1'b1;
    nreset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready_o: got %b want 1", bus.ready_o); end
  endtask

  task automatic test_latency();
    bus.ready_i = 1'b1;
    drive_op(1'b1, 16'h3F80, 16'h3F80);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive_op(1'b0, 16'($urandom), 16'($urandom));
      checks++;
      if (bus.valid_o !== (c == 3)) begin
        errors++; $display("FAIL latency_cycle%0d: valid_o got %b want %b", c, bus.valid_o, (c == 3));
      end
      if (c < 3) @(posedge clk);
    end
    checks++;
    if (out_word() !== 16'h0000) begin errors++; $display("FAIL one_minus_one: got %h want 0000", out_word()); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL latency_no_dup: valid_o got %b want 0", bus.valid_o); end
  endtask

  task automatic test_directed();
    logic [15:0] va [16] = '{16'h4000, 16'h3F80, 16'h3F80, 16'h7F80, 16'h7F7F, 16'h7FC1, 16'h8000, 16'h0000,
                             16'h8000, 16'h0055, 16'hFF80, 16'h3F80, 16'hFF80, 16'h7F80, 16'h0100, 16'h7F7F};
    logic [15:0] vb [16] = '{16'h3F00, 16'hBB80, 16'h3B80, 16'h7F80, 16'hFF7F, 16'h3F80, 16'h0000, 16'h8000,
                             16'h8000, 16'h0000, 16'h3F80, 16'h7F80, 16'hFF80, 16'hFF80, 16'h0120, 16'hFB00};
    logic [15:0] ve [16] = '{16'h3FC0, 16'h3F80, 16'h3F7F, 16'h7FC0, 16'h7F80, 16'h7FC0, 16'h8000, 16'h0000,
                             16'h0000, 16'h0000, 16'hFF80, 16'hFF80, 16'h7FC0, 16'h7F80, 16'h8000, 16'h7F80};
    int n;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_op(1'b1, va[i], vb[i]);
      @(posedge clk);
      @(negedge clk);
      drive_op(1'b0, 16'($urandom), 16'($urandom));
      n = 0;
      while (!bus.valid_o && n < 8) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      checks++;
      if (!bus.valid_o) begin
        errors++; $display("FAIL directed%0d_timeout: no valid_o within 8 cycles", i);
      end else if (out_word() !== ve[i]) begin
        errors++; $display("FAIL directed%0d %h-%h: got %h want %h", i, va[i], vb[i], out_word(), ve[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] oa [4] = '{16'h4000, 16'h3F80, 16'h4040, 16'hC2C8};
    logic [15:0] ob [4] = '{16'h3F00, 16'h3B80, 16'h3F80, 16'h4123};
    logic [15:0] ex [4];
    int idx = 0, got = 0, stall_left = 0, cyc = 0;
    logic seen_first = 1'b0;
    for (int i = 0; i < 4; i++) ex[i] = model(oa[i], ob[i]);
    while (got < 4 && cyc < 30) begin
      if (idx < 4) drive_op(1'b1, oa[idx], ob[idx]);
      else         drive_op(1'b0, 16'($urandom), 16'($urandom));
      if (!seen_first && bus.valid_o) begin
        seen_first = 1'b1;
        stall_left = 2;
      end
      bus.ready_i = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        checks++;
        if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall_ready_o: got %b want 0", bus.ready_o); end
        checks++;
        if (bus.valid_o !== 1'b1 || out_word() !== ex[0]) begin
          errors++; $display("FAIL bp_stall_hold: valid %b got %h want %h", bus.valid_o, out_word(), ex[0]);
        end
        stall_left--;
      end
      if (bus.valid_o && bus.ready_i) begin
        checks++;
        if (out_word() !== ex[got]) begin
          errors++; $display("FAIL bp_result%0d: got %h want %h", got, out_word(), ex[got]);
        end
        got++;
      end
      if (bus.valid_i && bus.ready_o) idx++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL bp_timeout: got %0d results want 4", got); end
    bus.ready_i = 1'b1;
    drive_op(1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_dup%0d: valid_o got %b want 0", c, bus.valid_o); end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    logic [15:0] q[$];
    logic [15:0] a, b, exp_w;
    int sent = 0, got = 0, cyc = 0;
    while (got < N && cyc < 5000) begin
      a = rand_op();
      b = rand_op();
      if ($urandom_range(0, 9) < 4 && a[14:7] >= 8'd40 && a[14:7] <= 8'd215)
        b = {a[15], 8'(int'(a[14:7]) + int'($urandom_range(0, 2)) - 1), 7'($urandom)};
      drive_op((sent < N) && ($urandom_range(0, 3) != 0), a, b);
      bus.ready_i = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.valid_o && bus.ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: got %h with nothing outstanding", out_word());
        end else begin
          exp_w = q.pop_front();
          if (out_word() !== exp_w) begin
            errors++; $display("FAIL rand_result%0d: got %h want %h", got, out_word(), exp_w);
          end
        end
        got++;
      end
      if (bus.valid_i && bus.ready_o) begin
        q.push_back(model(a, b));
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got != N) begin errors++; $display("FAIL rand_timeout: got %0d results want %0d", got, N); end
    drive_op(1'b0, 16'h0, 16'h0);
    bus.ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b1, 16'h4000 + 16'(i), 16'h3F80);
      @(posedge clk);
      @(negedge clk);
    end
    drive_op(1'b0, 16'h0, 16'h0);
    checks++;
    if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", bus.valid_o); end
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rm_async_valid: got %b want 0", bus.valid_o); end
    checks++;
    if (bus.ready_o !== 1'b1 || out_word() !== 16'h0000) begin
      errors++; $display("FAIL rm_async_clear: ready %b result %h want 1 and 0000", bus.ready_o, out_word());
    end
    @(posedge clk);
    @(negedge clk);
    bus.ready_i = 1'b1;
    nreset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      drive_op(1'b0, 16'($urandom), 16'($urandom));
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rm_stale%0d: valid_o got %b want 0", c, bus.valid_o); end
    end
  endtask

  initial begin
    drive_op(1'b0, 16'h0, 16'h0);
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
